inst_intensity_scheduler: RTL and testbench
===========================================

// Module: inst_intensity_scheduler
// PURPOSE
//  Owns per-instrument visual intensity accumulators and arbitrates one shared read-modify-write
//  path between two requesters: note-hit events (already in clk_pixel domain) and the per-frame
//  decay sweep. Sits between the MIDI/pad hit synchroniser and the visualiser renderer.
//  Publishes 8-bit intensities once per frame, after the decay sweep completes.
// PARAMETERS
//  INSTRUMENT_COUNT  3   number of tracked instruments / accumulators
//  FIFO_DEPTH        4   hit queue depth (power of 2, >=2)
// PORTS
//  clk_pixel       in   1                    pixel clock; all logic on this clock
//  rst             in   1                    synchronous, active-high reset
//  hit_valid       in   1                    hit request valid
//  hit_ready       out  1                    hit accepted when hit_valid && hit_ready
//  hit_inst        in   $clog2(INST_COUNT)   target instrument index
//  hit_velocity    in   7                    hit velocity
//  new_frame       in   1                    1-cycle frame strobe; starts decay sweep
//  decay_step      in   16 x INST_COUNT      per-instrument decrement per frame (static within a frame)
//  inst_intensity  out  8 x INST_COUNT       published intensities (acc[15:8])
//  frame_done      out  1                    1-cycle pulse in the cycle publish completes
//  busy            out  1                    high in SWEEP or PUBLISH
//  frame_overrun   out  1                    sticky: new_frame arrived while busy
//  drop_count      out  8                    saturating count of hits with out-of-range hit_inst
// BEHAVIOUR
//  - Reset: acc[*]=0, inst_intensity[*]=0, FIFO empty, hit_ready=1, frame_done=0, busy=0,
//    frame_overrun=0, drop_count=0, state=IDLE, sweep index=0. Reset mid-sweep aborts, nothing published.
//  - hit_ready = !fifo_full (registered-independent; low when full even if a pop occurs same cycle).
//  - Accepted hit pushed at edge t. Out-of-range hit_inst (>=INSTRUMENT_COUNT): accepted, not
//    pushed, drop_count++ (saturate at 255).
//  - FSM IDLE: new_frame -> SWEEP (idx=0) at next edge; hits are not popped in a new_frame cycle.
//    Otherwise, if FIFO non-empty: pop one entry per cycle, acc[inst] <= {vel,9'b0} (same edge).
//    Min hit latency: push edge t, acc written edge t+1.
//  - SWEEP: one instrument per cycle: acc[idx] <= (acc[idx] > decay_step[idx]) ? acc-step : 0;
//    idx++; after idx==INSTRUMENT_COUNT-1 -> PUBLISH. FIFO frozen (pushes allowed, no pops).
//  - PUBLISH (1 cycle): inst_intensity[i] <= acc[i][15:8] for all i; frame_done=1; -> IDLE.
//    Frame cost = INSTRUMENT_COUNT+1 cycles after new_frame edge.
//  - new_frame while busy: ignored, frame_overrun <= 1 (cleared only by rst).
//  - Hit and decay never touch acc in the same cycle; same-instrument ordering preserved by FIFO.
//  - Arithmetic: 16-bit unsigned, no wrap; subtraction floors at 0, equal values give 0.
// CONFIGURATION
//  HIT_MAX_MERGE_EN defined: hit writes acc[inst] <= max(acc[inst], {vel,9'b0}) (soft hit never
//    dims a louder decaying one). Undefined: hit overwrites acc[inst] unconditionally.
// STRUCTURE
//  Package viz_pkg: sched_state_e {IDLE,SWEEP,PUBLISH}; hit_entry_t struct {inst, velocity};
//    INST_IDX_W localparam helper; ACC_W=16 constant.
//  Sub-module hit_fifo: synchronous FIFO of hit_entry_t (push/pop/full/empty, FIFO_DEPTH).
// TESTING
//  1. Hit inst=1 vel=0x40 in IDLE, then new_frame with decay_step[1]=0x0100 -> acc[1]=0x7F00,
//     inst_intensity[1]=0x7F one cycle after sweep, frame_done pulses at new_frame edge+4 (N=3).
//  2. acc[0]=0x0010, decay_step[0]=0x0010 -> acc[0]=0 (floor, no wrap); step=0x0020 -> also 0.
//  3. Push 5 hits during SWEEP with FIFO_DEPTH=4 -> hit_ready low after 4th, 5th stalls until
//     PUBLISH ends; all drained in order, one per cycle in IDLE.
//  4. new_frame again 2 cycles after first -> ignored, frame_overrun=1, single frame_done.
//  5. hit_inst=3 (N=3) x300 -> drop_count saturates 255, acc untouched.
//  6. rst asserted mid-SWEEP -> all outputs reset values next cycle, no frame_done;
//     HIT_MAX_MERGE_EN: acc=0x7F00 then hit vel=0x10 -> stays 0x7F00 (overwrites to 0x2000 without).

Source files
------------

// File: rtl/viz_pkg.sv
// Shared types and helpers for the instrument intensity scheduler.
package viz_pkg;

   localparam int ACC_W        = 16;
   localparam int VEL_W        = 7;
   localparam int INST_FIELD_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      PUBLISH
   } sched_state_e;

   typedef struct packed {
      logic [INST_FIELD_W-1:0] inst;
      logic [VEL_W-1:0]        velocity;
   } hit_entry_t;

   // Index width for n instruments, never narrower than one bit.
   function automatic int inst_idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inst_intensity_scheduler_hit_fifo.sv
// Synchronous FIFO of pending hits; full/empty come straight from the pointers.
module hit_fifo
   import viz_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic       push,
   input  hit_entry_t push_data,
   input  logic       pop,
   output hit_entry_t pop_data,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   hit_entry_t     mem [FIFO_DEPTH];

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
         if (pop && !empty) rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/inst_intensity_scheduler.sv
// Per-instrument intensity accumulators with hit/decay arbitration and per-frame publish.
// Build option: define HIT_MAX_MERGE_EN to make hits keep the louder of old and new value.
module inst_intensity_scheduler
   import viz_pkg::*;
#(
   parameter int INSTRUMENT_COUNT = 3,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                                  clk_pixel,
   input  logic                                  rst,
   input  logic                                  hit_valid,
   output logic                                  hit_ready,
   input  logic [inst_idx_w(INSTRUMENT_COUNT)-1:0] hit_inst,
   input  logic [VEL_W-1:0]                      hit_velocity,
   input  logic                                  new_frame,
   input  logic [ACC_W*INSTRUMENT_COUNT-1:0]     decay_step,
   output logic [8*INSTRUMENT_COUNT-1:0]         inst_intensity,
   output logic                                  frame_done,
   output logic                                  busy,
   output logic                                  frame_overrun,
   output logic [7:0]                            drop_count
);

   localparam int INST_IDX_W = inst_idx_w(INSTRUMENT_COUNT);

   sched_state_e          state;
   sched_state_e          state_d;
   logic [INST_IDX_W-1:0] idx;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  accept;
   logic                  in_range;
   logic                  push;
   logic                  pop;
   hit_entry_t            push_entry;
   hit_entry_t            pop_entry;
   logic [INST_IDX_W-1:0] pop_inst;
   logic [ACC_W-1:0]      hit_val;
   logic [ACC_W-1:0]      acc  [INSTRUMENT_COUNT];
   logic [ACC_W-1:0]      step [INSTRUMENT_COUNT];

   function automatic logic [ACC_W-1:0] decay(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] s);
      return (a > s) ? a - s : '0;
   endfunction

   function automatic logic [ACC_W-1:0] hit_write(input logic [ACC_W-1:0] old_val,
                                                   input logic [ACC_W-1:0] new_val);
`ifdef HIT_MAX_MERGE_EN
      return (new_val > old_val) ? new_val : old_val;
`else
      return new_val;
`endif
   endfunction

   assign hit_ready  = !fifo_full;
   assign accept     = hit_valid && hit_ready;
   assign in_range   = int'(hit_inst) < INSTRUMENT_COUNT;
   assign push       = accept && in_range;
   assign push_entry = '{inst: INST_FIELD_W'(hit_inst), velocity: hit_velocity};
   assign pop_inst   = INST_IDX_W'(pop_entry.inst);
   assign hit_val    = {pop_entry.velocity, 9'b0};
   assign busy       = (state != IDLE);

   always_comb begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) step[i] = decay_step[i*ACC_W +: ACC_W];
   end

   hit_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_hit_fifo (
      .clk_pixel(clk_pixel),
      .rst      (rst),
      .push     (push),
      .push_data(push_entry),
      .pop      (pop),
      .pop_data (pop_entry),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Hits only drain in IDLE, so a hit and a decay never write acc in the same cycle.
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (new_frame)        state_d = SWEEP;
            else if (!fifo_empty) pop     = 1'b1;
         end
         SWEEP:   if (idx == INST_IDX_W'(INSTRUMENT_COUNT - 1)) state_d = PUBLISH;
         PUBLISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         idx           <= '0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;
         drop_count    <= '0;
      end else begin
         frame_done <= (state == PUBLISH);
         idx        <= (state == SWEEP) ? idx + INST_IDX_W'(1) : '0;
         if (new_frame && busy) frame_overrun <= 1'b1;
         if (accept && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         for (int i = 0; i < INSTRUMENT_COUNT; i++) acc[i] <= '0;
         inst_intensity <= '0;
      end else begin
         if (pop) acc[pop_inst] <= hit_write(acc[pop_inst], hit_val);
         if (state == SWEEP) acc[idx] <= decay(acc[idx], step[idx]);
         if (state == PUBLISH) begin
            for (int i = 0; i < INSTRUMENT_COUNT; i++)
               inst_intensity[i*8 +: 8] <= acc[i][ACC_W-1 -: 8];
         end
      end
   end

endmodule

// File: tb/tb_inst_intensity_scheduler.sv
// Scoreboard bench: expected published intensities are queued at each new_frame and checked on frame_done.
module tb_inst_intensity_scheduler;

   localparam int N = 3;

   logic        clk_pixel = 1'b0;
   logic        rst;
   logic        hit_valid;
   logic        hit_ready;
   logic [1:0]  hit_inst;
   logic [6:0]  hit_velocity;
   logic        new_frame;
   logic [47:0] decay_step;
   logic [23:0] inst_intensity;
   logic        frame_done;
   logic        busy;
   logic        frame_overrun;
   logic [7:0]  drop_count;

   inst_intensity_scheduler #(
      .INSTRUMENT_COUNT(N),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk_pixel     (clk_pixel),
      .rst           (rst),
      .hit_valid     (hit_valid),
      .hit_ready     (hit_ready),
      .hit_inst      (hit_inst),
      .hit_velocity  (hit_velocity),
      .new_frame     (new_frame),
      .decay_step    (decay_step),
      .inst_intensity(inst_intensity),
      .frame_done    (frame_done),
      .busy          (busy),
      .frame_overrun (frame_overrun),
      .drop_count    (drop_count)
   );

   always #5 clk_pixel = ~clk_pixel;

   typedef struct {
      int          cyc;
      logic [23:0] val;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   exp_t        sb [$];
   exp_t        got;
   logic [15:0] m_acc [N];

   always @(posedge clk_pixel) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_decay(input logic [15:0] a, input logic [15:0] s);
      return (a <= s) ? 16'h0000 : a - s;
   endfunction

   function automatic logic [15:0] m_hit(input logic [15:0] a, input logic [6:0] v);
      logic [15:0] h;
      h = {v, 9'h000};
`ifdef HIT_MAX_MERGE_EN
      return (h > a) ? h : a;
`else
      return h;
`endif
   endfunction

   always @(negedge clk_pixel) begin
      if (rst === 1'b0 && frame_done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_done", frame_done, 0);
         end else begin
            got = sb.pop_front();
            chk("done_cycle", cyc, got.cyc);
            chk("intensity", inst_intensity, got.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic settle();
      repeat (8) tick();
   endtask

   task automatic drive_hit(input int inst, input logic [6:0] vel, output int waited);
      hit_valid    = 1'b1;
      hit_inst     = inst[1:0];
      hit_velocity = vel;
      waited       = 0;
      while (!hit_ready && waited < 100) begin
         tick();
         waited++;
      end
      if (!hit_ready) chk("hit_timeout", hit_ready, 1);
      tick();
      hit_valid = 1'b0;
      if (inst < N) m_acc[inst] = m_hit(m_acc[inst], vel);
   endtask

   task automatic start_frame(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
      exp_t        e;
      logic [15:0] s [N];
      s[0] = s0; s[1] = s1; s[2] = s2;
      decay_step = {s2, s1, s0};
      for (int i = 0; i < N; i++) begin
         m_acc[i] = m_decay(m_acc[i], s[i]);
         e.val[i*8 +: 8] = m_acc[i][15:8];
      end
      e.cyc = cyc + 5;
      sb.push_back(e);
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
   endtask

   initial begin
      int w;
      rst          = 1'b1;
      hit_valid    = 1'b0;
      hit_inst     = '0;
      hit_velocity = '0;
      new_frame    = 1'b0;
      decay_step   = '0;
      for (int i = 0; i < N; i++) m_acc[i] = 16'h0000;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_intensity", inst_intensity, 0);
      chk("rst_ready", hit_ready, 1);
      chk("rst_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", frame_overrun, 0);
      chk("rst_drop", drop_count, 0);

      // basic hit then decayed publish
      drive_hit(1, 7'h40, w);
      settle();
      start_frame(16'h0000, 16'h0100, 16'h0000);
      chk("sweep_busy", busy, 1);
      settle();
      chk("t1_intensity1", inst_intensity[15:8], 8'h7F);

      // soft hit on a louder accumulator
      drive_hit(1, 7'h10, w);
      settle();
      start_frame(16'h0000, 16'h0000, 16'h0000);
      settle();

      // floor at zero: equal and larger step
      drive_hit(0, 7'h01, w);
      settle();
      start_frame(16'h01F0, 16'h0000, 16'h0000);
      settle();
      start_frame(16'h0020, 16'h0000, 16'h0000);
      settle();
      drive_hit(0, 7'h01, w);
      settle();
      start_frame(16'h01F0, 16'h0000, 16'h0000);
      settle();
      start_frame(16'h0010, 16'h0000, 16'h0000);
      settle();

      // FIFO fills during the sweep and drains in order afterwards
      start_frame(16'h0000, 16'h0000, 16'h0000);
      drive_hit(0, 7'h10, w);
      drive_hit(1, 7'h20, w);
      drive_hit(2, 7'h30, w);
      drive_hit(0, 7'h05, w);
      chk("full_ready", hit_ready, 0);
      drive_hit(1, 7'h7F, w);
      chk("stall_cycles", w, 1);
      settle();
      start_frame(16'h0000, 16'h0000, 16'h0000);
      settle();

      // overlapping new_frame is ignored and flagged
      chk("pre_overrun", frame_overrun, 0);
      start_frame(16'h0000, 16'h0000, 16'h0000);
      tick();
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      chk("overrun", frame_overrun, 1);
      settle();

      // out-of-range hits only count
      hit_valid    = 1'b1;
      hit_inst     = 2'd3;
      hit_velocity = 7'h7F;
      repeat (10) tick();
      chk("drop_10", drop_count, 10);
      repeat (290) tick();
      hit_valid = 1'b0;
      chk("drop_sat", drop_count, 255);
      settle();
      start_frame(16'h0000, 16'h0000, 16'h0000);
      settle();

      // reset in the middle of a sweep
      start_frame(16'h0100, 16'h0100, 16'h0100);
      tick();
      rst = 1'b1;
      tick();
      sb.delete();
      for (int i = 0; i < N; i++) m_acc[i] = 16'h0000;
      chk("mid_rst_intensity", inst_intensity, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_overrun", frame_overrun, 0);
      chk("mid_rst_drop", drop_count, 0);
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_ready", hit_ready, 1);
      rst = 1'b0;
      settle();
      chk("post_rst_done", frame_done, 0);
      drive_hit(2, 7'h11, w);
      settle();
      start_frame(16'h0000, 16'h0000, 16'h0200);
      settle();

      for (int n = 0; n < 50 && sb.size() > 0; n++) tick();
      chk("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
